// File: rtl/spi_slave_byte_if_if.sv
// SPI pin and byte-stream bundle shared by spi_slave_byte_if and whatever drives it.
// The slave modport is the view of the SPI front end; master is the pins/consumer side.
interface spi_slave_byte_if_if;
    logic       spi_sclk_i;
    logic       spi_ss_i;
    logic       spi_mosi_i;
    logic       spi_miso_o;
    logic       spi_miso_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       frame_active_o;
    logic       frame_end_o;
    logic       overrun_o;

    modport slave (
        input  spi_sclk_i, spi_ss_i, spi_mosi_i, rx_ready_i, tx_data_i, tx_valid_i,
        output spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
               frame_active_o, frame_end_o, overrun_o
    );

    modport master (
        output spi_sclk_i, spi_ss_i, spi_mosi_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
               frame_active_o, frame_end_o, overrun_o
    );
endinterface

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave front end oversampled in the block clock: MOSI bytes into an RX FIFO,
// TX bytes onto MISO. Define SPI_SLAVE_FRAME_CNT_EN to add the per-frame byte counter.
module spi_slave_byte_if #(
    parameter int         RX_DEPTH = 4,
    parameter logic [7:0] TX_IDLE  = 8'hFF
) (
    input  logic               block_clk_i,
    input  logic               rst_i,
    spi_slave_byte_if_if.slave bus
`ifdef SPI_SLAVE_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_bytes_o
`endif
);
    localparam int             PTR_W    = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RX_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e             state_q, state_d;
    logic [2:0]         sclk_sync_q, sclk_sync_d;
    logic [2:0]         ss_sync_q, ss_sync_d;
    logic [2:0]         mosi_sync_q, mosi_sync_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               byte_done_q, byte_done_d;
    logic               miso_q, miso_d;
    logic               miso_oe_q, miso_oe_d;
    logic               tx_ready_q, tx_ready_d;
    logic               frame_active_q, frame_active_d;
    logic               frame_end_q, frame_end_d;
    logic               overrun_q, overrun_d;
    logic               rx_valid_q, rx_valid_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [7:0]         mem_q [RX_DEPTH];
    logic [7:0]         mem_d [RX_DEPTH];
`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic [7:0]         frame_bytes_q, frame_bytes_d;
`endif

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic pop, push_ok, full;

    // Edges come from stage 2 vs stage 3; mosi stage 2 lines up with the sclk edge seen.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];

    assign full    = (count_q == FULL_CNT);
    assign pop     = rx_valid_q & bus.rx_ready_i;
    assign push_ok = byte_done_q & (~full | pop);

    always_comb begin
        // NOTE: every _d takes its held value first, so no branch can infer a latch.
        state_d        = state_q;
        sclk_sync_d    = {sclk_sync_q[1:0], bus.spi_sclk_i};
        ss_sync_d      = {ss_sync_q[1:0], bus.spi_ss_i};
        mosi_sync_d    = {mosi_sync_q[1:0], bus.spi_mosi_i};
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        byte_done_d    = 1'b0;
        miso_d         = miso_q;
        miso_oe_d      = miso_oe_q;
        tx_ready_d     = 1'b0;
        frame_end_d    = 1'b0;
        overrun_d      = overrun_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        mem_d          = mem_q;
`ifdef SPI_SLAVE_FRAME_CNT_EN
        frame_bytes_d  = frame_bytes_q;
        if (byte_done_q && frame_bytes_q != 8'hFF) begin
            frame_bytes_d = frame_bytes_q + 8'd1;
        end
`endif

        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                miso_oe_d = 1'b0;
                miso_d    = 1'b0;
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    miso_oe_d = 1'b1;
                    if (bus.tx_valid_i) begin
                        tx_shift_d = bus.tx_data_i;
                        tx_ready_d = 1'b1;
                    end else begin
                        tx_shift_d = TX_IDLE;
                    end
                    miso_d = tx_shift_d[7];
`ifdef SPI_SLAVE_FRAME_CNT_EN
                    frame_bytes_d = 8'd0;
`endif
                end
            end
            ACTIVE: begin
                // A deselect in the same cycle as an sclk edge drops that edge.
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                    miso_oe_d   = 1'b0;
                    miso_d      = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d  = {rx_shift_q[6:0], mosi_sync_q[1]};
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_done_d = (bit_cnt_q == 3'd7);
                    end
                    if (sclk_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            if (bus.tx_valid_i) begin
                                tx_shift_d = bus.tx_data_i;
                                tx_ready_d = 1'b1;
                            end else begin
                                tx_shift_d = TX_IDLE;
                            end
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                        miso_d = tx_shift_d[7];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        if (byte_done_q && full && !pop) begin
            overrun_d = 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_ptr_q] = rx_shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        rx_valid_d     = (count_d != '0);
        frame_active_d = (state_d == ACTIVE);
    end

    always_ff @(posedge block_clk_i or posedge rst_i) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (rst_i) begin
            state_q        <= IDLE;
            sclk_sync_q    <= '0;
            ss_sync_q      <= '0;
            mosi_sync_q    <= '0;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            byte_done_q    <= 1'b0;
            miso_q         <= 1'b0;
            miso_oe_q      <= 1'b0;
            tx_ready_q     <= 1'b0;
            frame_active_q <= 1'b0;
            frame_end_q    <= 1'b0;
            overrun_q      <= 1'b0;
            rx_valid_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            // NOTE: the storage is reset because rx_data_o reads the head directly and must be 0.
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef SPI_SLAVE_FRAME_CNT_EN
            frame_bytes_q  <= '0;
`endif
        end else begin
            state_q        <= state_d;
            sclk_sync_q    <= sclk_sync_d;
            ss_sync_q      <= ss_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            byte_done_q    <= byte_done_d;
            miso_q         <= miso_d;
            miso_oe_q      <= miso_oe_d;
            tx_ready_q     <= tx_ready_d;
            frame_active_q <= frame_active_d;
            frame_end_q    <= frame_end_d;
            overrun_q      <= overrun_d;
            rx_valid_q     <= rx_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            mem_q          <= mem_d;
`ifdef SPI_SLAVE_FRAME_CNT_EN
            frame_bytes_q  <= frame_bytes_d;
`endif
        end
    end

    assign bus.spi_miso_o     = miso_q;
    assign bus.spi_miso_oe_o  = miso_oe_q;
    assign bus.rx_data_o      = mem_q[rd_ptr_q];
    assign bus.rx_valid_o     = rx_valid_q;
    assign bus.tx_ready_o     = tx_ready_q;
    assign bus.frame_active_o = frame_active_q;
    assign bus.frame_end_o    = frame_end_q;
    assign bus.overrun_o      = overrun_q;
`ifdef SPI_SLAVE_FRAME_CNT_EN
    assign frame_bytes_o      = frame_bytes_q;
`endif
endmodule
